// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one variable-latency memory between fetch and data ports
module mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_D_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

   state_t     state, state_nxt;
   logic       grant_i, grant_d;
   logic       ack_i, ack_d;
   logic [3:0] d_run;

   // acks only count while a transaction is outstanding; IDLE/RESP acks are dropped
   assign ack_i = (state == BUSY_I) && mem_ack;
   assign ack_d = (state == BUSY_D) && mem_ack;

   // the pipeline advances on the edge that ends the done cycle
   assign stall_if  = i_req & ~i_done;
   assign stall_mem = d_req & ~d_done;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state and grant choice: data wins unless fetch has waited MAX_D_RUN grants
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !(i_req && (d_run == RUN_MAX))) begin
               grant_d   = 1'b1;
               state_nxt = BUSY_D;
            end else if (i_req) begin
               grant_i   = 1'b1;
               state_nxt = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: if (mem_ack) state_nxt = RESP;
         RESP:           state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   // memory-side request registers, held stable until the ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_d) begin
         mem_req   <= 1'b1;
         mem_we    <= d_we;
         mem_addr  <= d_addr;
         mem_wdata <= d_wdata;
      end else if (grant_i) begin
         mem_req   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= i_addr;
      end else if (ack_i || ack_d) begin
         mem_req   <= 1'b0;
      end
   end

   // completion pulses and read-data capture; write completions keep d_rdata
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_done <= ack_i;
         d_done <= ack_d;
         if (ack_i)            i_rdata <= mem_rdata;
         if (ack_d && !mem_we) d_rdata <= mem_rdata;
      end
   end

   // consecutive data grants while fetch is waiting, saturating at the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_run <= 4'd0;
      end else if (grant_i) begin
         d_run <= 4'd0;
      end else if (grant_d) begin
         if (!i_req)                d_run <= 4'd0;
         else if (d_run != RUN_MAX) d_run <= d_run + 4'd1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_done, d_done, mem_req, mem_we, stall_if, stall_mem;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   txn_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_i, last_d;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic push(input logic is_d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
      txn_t t;
      t.is_d = is_d; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      sb.push_back(t);
   endtask

   // acts as the memory: waits for a request, acks after lat cycles, then
   // compares the completion against the oldest scoreboard entry; returns in the done cycle
   task automatic serve_one(input int lat);
      txn_t        e;
      int          n;
      logic [31:0] a0;
      n = 0;
      while (mem_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (mem_req !== 1'b1) begin
         check("grant_timeout", 32'(mem_req), 1);
         return;
      end
      if (sb.size() == 0) begin
         check("sb_underflow", sb.size(), 1);
         return;
      end
      e = sb.pop_front();
      check("mem_addr", mem_addr, e.addr);
      check("mem_we", 32'(mem_we), 32'(e.we));
      if (e.we) check("mem_wdata", mem_wdata, e.wdata);
      a0 = mem_addr;
      for (int k = 0; k < lat; k++) begin
         check("hold_req", 32'(mem_req), 1);
         check("hold_addr", mem_addr, a0);
         check("stall_busy", 32'(e.is_d ? stall_mem : stall_if), 1);
         check("done_early", 32'(i_done | d_done), 0);
         if (k == lat - 1) begin
            mem_ack   = 1'b1;
            mem_rdata = e.rdata;
         end
         @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      check("i_done", 32'(i_done), 32'(!e.is_d));
      check("d_done", 32'(d_done), 32'(e.is_d));
      check("req_drop", 32'(mem_req), 0);
      check("stall_done", 32'(e.is_d ? stall_mem : stall_if), 0);
      if (!e.is_d) last_i = e.rdata;
      else if (!e.we) last_d = e.rdata;
      check("i_rdata", i_rdata, last_i);
      check("d_rdata", d_rdata, last_d);
   endtask

   // the cycle after done: pulse must be gone and no new request yet
   task automatic post_done();
      @(negedge clk);
      check("pulse_len", 32'(i_done | d_done), 0);
      check("resp_noreq", 32'(mem_req), 0);
   endtask

   initial begin
      int          order[6];
      int          nd;
      int          n;
      logic [31:0] rd;
      order = '{1, 1, 1, 1, 0, 1};
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      last_i = '0; last_d = '0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_dones", 32'({i_done, d_done}), 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      rst = 1'b0;

      // fetch, memory acks after 2 cycles
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h40;
      push(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C220004);
      serve_one(2);
      i_req = 1'b0;
      post_done();

      // data read, ack delayed 5 cycles
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      push(1'b1, 1'b0, 32'h80, 32'h0, 32'h12345678);
      serve_one(5);
      d_req = 1'b0;
      post_done();

      // data write leaves d_rdata alone
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
      push(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h55AA55AA);
      serve_one(1);
      d_req = 1'b0; d_we = 1'b0;
      post_done();

      // spurious ack with nothing outstanding
      mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
      @(negedge clk);
      mem_ack = 1'b0;
      check("spur_done", 32'(i_done | d_done), 0);
      @(negedge clk);
      check("spur_done2", 32'(i_done | d_done), 0);
      check("spur_req", 32'(mem_req), 0);
      check("spur_i_rdata", i_rdata, last_i);
      check("spur_d_rdata", d_rdata, last_d);

      // reset while BUSY_D, late ack after release
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      n = 0;
      while (mem_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_busy_grant", 32'(mem_req), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_mem_req", 32'(mem_req), 0);
      check("arst_mem_addr", mem_addr, 0);
      check("arst_rdata", i_rdata | d_rdata, 0);
      d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      last_i = '0; last_d = '0;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h0000ABCD;
      @(negedge clk);
      mem_ack = 1'b0;
      check("late_ack_done", 32'(i_done | d_done), 0);
      check("late_ack_req", 32'(mem_req), 0);
      check("late_ack_d_rdata", d_rdata, 0);
      @(negedge clk);
      check("late_ack_done2", 32'(i_done | d_done), 0);
      check("late_ack_req2", 32'(mem_req), 0);

      // both requesting: data wins four times, then fetch gets one grant
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
      nd = 0;
      for (int j = 0; j < 6; j++) begin
         rd = 32'hA0000000 + 32'(j);
         if (order[j] == 1) begin
            push(1'b1, 1'b0, 32'h200 + 32'(4 * nd), 32'h0, rd);
            nd++;
         end else begin
            push(1'b0, 1'b0, 32'h100, 32'h0, rd);
         end
      end
      for (int j = 0; j < 6; j++) begin
         serve_one(1);
         if (order[j] == 1) d_addr = d_addr + 32'd4;
         else               i_req = 1'b0;
         if (j == 5) d_req = 1'b0;
         post_done();
      end
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and data-access port. It serialises requests, drives the memory handshake, returns read data to the winning port, and produces the IF and MEM stall signals the pipeline uses to hold its stage registers. Data access has priority over fetch, with a starvation guard for fetch.

## Interface
- ADDR_W, 32, address width for both ports and memory
- DATA_W, 32, data width
- MAX_D_RUN, 4, maximum consecutive data grants while fetch waits; range 1..15
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  fetch request; held until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req high
- i_rdata  out  DATA_W  fetch read data
- i_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = write, 0 = read; stable while d_req high
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  data read result
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in mem_ack cycle
- mem_ack  in  1  memory completion, one cycle
- stall_if  out  1  i_req & ~i_done (combinational)
- stall_mem  out  1  d_req & ~d_done (combinational)

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: no req -> stay. Only i_req -> grant I. Only d_req -> grant D. Both -> grant D unless d_run == MAX_D_RUN, then grant I.
- Grant: register address (and d_we, d_wdata for D; mem_we=0 for I) into mem_addr/mem_we/mem_wdata, set mem_req=1, go BUSY_I/BUSY_D.
- BUSY_x: mem_* held stable; mem_ack low -> stay. mem_ack high -> mem_req<=0, x_done<=1, go RESP; for reads x_rdata<=mem_rdata; D writes leave d_rdata unchanged.
- RESP: x_done high this cycle only; no grant issued; next IDLE. Requester removes or replaces its request in the done cycle.
- d_run (4-bit): instruction grant -> 0; data grant with i_req high -> +1 saturating at MAX_D_RUN; data grant with i_req low -> 0.
- mem_ack in IDLE or RESP ignored. Request dropped mid-transaction: transaction completes, done still pulses.
- i_rdata/d_rdata hold last value until next read completion on that port.

## Timing
- Reset (async): state IDLE, mem_req/mem_we/i_done/d_done 0, mem_addr/mem_wdata/i_rdata/d_rdata 0, d_run 0. Reset mid-transaction abandons it; later mem_ack ignored.
- Request sampled high at edge E0 (IDLE) -> mem_req high from cycle after E0.
- mem_ack sampled at edge Ea -> mem_req low and x_done high, rdata valid the cycle after Ea; IDLE one cycle later.
- Minimum occupancy 3 cycles per transaction (memory acking in first request cycle); back-to-back throughput one transaction per 3 cycles.
- stall_if/stall_mem fall in the done cycle, so the pipeline advances on that edge.

## Test plan
- Reset then d_req=0,i_req=1,i_addr=0x40, memory acks after 2 cycles with 0x8C220004 -> mem_addr=0x40, mem_we=0, i_done one cycle, i_rdata=0x8C220004, stall_if low in done cycle.
- d_req write d_addr=0x10 d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_done pulses, d_rdata unchanged.
- i_req and d_req asserted together (d_req re-asserted after every d_done, MAX_D_RUN=4) -> grant order D,D,D,D,I,D.
- Memory ack delayed 5 cycles -> mem_req and mem_addr stable all 5 cycles, stall_mem high throughout, exactly one d_done.
- rst asserted while BUSY_D, mem_ack arrives 1 cycle after rst release -> all outputs 0 immediately, no done pulse, stays IDLE.
- Spurious mem_ack in IDLE with no requests -> no done pulse, no rdata change.
